// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: adapts a 1-cycle-latency sync FIFO read port to a valid/ready stream via a 2-entry buffer.
// Optional FIFO_RD_CNT_EN adds the rd_count port counting delivered words.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [15:0]           rd_count
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} occ_t;
    occ_t occ, occ_n;
    logic inflight, pop;
    logic [2:0] level;
    logic [DATA_WIDTH-1:0] head, tail, head_n, tail_n;
    assign m_valid = (occ != EMPTY);
    assign m_data  = head;
    always_comb begin
        pop        = m_valid && m_ready;
        level      = 3'(occ) + 3'(inflight) - 3'(pop);
        fifo_rd_en = !rst && !fifo_empty && (level < 3'd2);
        occ_n      = (level == 3'd0) ? EMPTY : (level == 3'd1) ? ONE : TWO;
        head_n     = pop ? tail : head;
        tail_n     = tail;
        // the returning word lands in the first slot left free after any pop
        if (inflight) begin
            if (level == 3'd1) head_n = fifo_dout;
            else tail_n = fifo_dout;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ      <= EMPTY;
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
        end else begin
            occ      <= occ_n;
            inflight <= fifo_rd_en;
            head     <= head_n;
            tail     <= tail_n;
        end
    end
`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_count <= '0;
        else if (pop) rd_count <= rd_count + 16'd1;
    end
`endif
endmodule
